// File: rtl/i2c_slave_rx.sv
// I2C write-only target: oversamples SCL/SDA, matches the 7-bit address,
// ACKs address and data bytes, and hands each byte out on an AXI-Stream port.
module i2c_slave_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [ADDR_WIDTH-1:0] own_addr,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ACK_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_ACK_DATA = 3'd4;
    localparam logic [2:0] ST_IGNORE   = 3'd5;

    logic [1:0]            scl_sync_q, scl_sync_d;
    logic [1:0]            sda_sync_q, sda_sync_d;
    logic                  scl_p_q, scl_p_d;
    logic                  sda_p_q, sda_p_d;
    logic [2:0]            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  ack_phase_q, ack_phase_d;
    logic                  ack_pending_q, ack_pending_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  overrun_q, overrun_d;

    logic                  s_scl, s_sda;
    logic                  scl_rise, scl_fall, start_evt, stop_evt;
    logic [DATA_WIDTH-1:0] shift_nxt;

    assign s_scl     = scl_sync_q[1];
    assign s_sda     = sda_sync_q[1];
    assign scl_rise  = s_scl & ~scl_p_q;
    assign scl_fall  = ~s_scl & scl_p_q;
    // SDA edge only counts as START/STOP while SCL was high in both samples.
    assign start_evt = s_scl & scl_p_q & sda_p_q & ~s_sda;
    assign stop_evt  = s_scl & scl_p_q & ~sda_p_q & s_sda;
    assign shift_nxt = {shift_q[DATA_WIDTH-2:0], s_sda};

    always_comb begin
        scl_sync_d    = {scl_sync_q[0], scl_i};
        sda_sync_d    = {sda_sync_q[0], sda_i};
        scl_p_d       = s_scl;
        sda_p_d       = s_sda;
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        ack_phase_d   = ack_phase_q;
        ack_pending_d = ack_pending_q;
        sda_oe_d      = sda_oe_q;
        busy_d        = busy_q;
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q;
        overrun_d     = 1'b0;

        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        if (stop_evt) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_evt) begin
            state_d  = ST_ADDR;
            cnt_d    = 3'd7;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sda_oe_d = 1'b0;
                end
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = shift_nxt;
                        cnt_d   = cnt_q - 3'd1;
                        if (cnt_q == 3'd0) begin
                            if (shift_nxt[ADDR_WIDTH:1] == own_addr && !shift_nxt[0]) begin
                                state_d     = ST_ACK_ADDR;
                                ack_phase_d = 1'b0;
                            end else begin
                                state_d = ST_IGNORE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                ST_ACK_ADDR: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe_d    = 1'b1;
                            busy_d      = 1'b1;
                            ack_phase_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_DATA;
                            cnt_d    = 3'd7;
                        end
                    end
                end
                ST_DATA: begin
                    if (scl_rise) begin
                        shift_d = shift_nxt;
                        cnt_d   = cnt_q - 3'd1;
                        if (cnt_q == 3'd0) begin
                            // Single-entry buffer: accept only if empty or draining this cycle.
                            if (!tvalid_q || m_axis_tready) begin
                                tdata_d       = shift_nxt;
                                tvalid_d      = 1'b1;
                                ack_pending_d = 1'b1;
                            end else begin
                                overrun_d     = 1'b1;
                                ack_pending_d = 1'b0;
                            end
                            state_d     = ST_ACK_DATA;
                            ack_phase_d = 1'b0;
                        end
                    end
                end
                ST_ACK_DATA: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe_d    = ack_pending_q;
                            ack_phase_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_DATA;
                            cnt_d    = 3'd7;
                        end
                    end
                end
                ST_IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            scl_sync_q    <= 2'b11;
            sda_sync_q    <= 2'b11;
            scl_p_q       <= 1'b1;
            sda_p_q       <= 1'b1;
            state_q       <= ST_IDLE;
            cnt_q         <= 3'd7;
            shift_q       <= '0;
            ack_phase_q   <= 1'b0;
            ack_pending_q <= 1'b0;
            sda_oe_q      <= 1'b0;
            busy_q        <= 1'b0;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            scl_sync_q    <= scl_sync_d;
            sda_sync_q    <= sda_sync_d;
            scl_p_q       <= scl_p_d;
            sda_p_q       <= sda_p_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            ack_phase_q   <= ack_phase_d;
            ack_pending_q <= ack_pending_d;
            sda_oe_q      <= sda_oe_d;
            busy_q        <= busy_d;
            tdata_q       <= tdata_d;
            tvalid_q      <= tvalid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign sda_oe        = sda_oe_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bus-level I2C master model, transfer-level reference
// model and a scoreboard monitor on the AXI-Stream output.
module tb_i2c_slave_rx;

    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic [6:0] own_addr = 7'h50;
    logic       scl_i = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic       busy;
    logic       overrun;

    // Open-drain bus: either side can pull SDA low.
    assign sda_i = sda_m & ~sda_oe;

    i2c_slave_rx #(.DATA_WIDTH(8), .ADDR_WIDTH(7)) dut (
        .clk(clk), .arst(arst), .own_addr(own_addr),
        .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         ovr_seen = 0;
    int         mdl_ovr = 0;
    bit         mdl_full = 1'b0;
    bit         oe_seen = 1'b0;
    logic [7:0] held;
    bit         stall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitq(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: pops an expected byte on every accepted beat.
    always @(negedge clk) begin
        if (arst) begin
            stall = 1'b0;
        end else begin
            if (sda_oe) oe_seen = 1'b1;
            if (overrun) ovr_seen++;
            if (m_axis_tvalid && stall) check("tdata_stable", 32'(m_axis_tdata), 32'(held));
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got 0x%0h expected no beat", m_axis_tdata);
                end else begin
                    check("tdata", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
                end
                stall = 1'b0;
            end else if (m_axis_tvalid) begin
                stall = 1'b1;
                held  = m_axis_tdata;
            end
        end
    end

    task automatic i2c_start();
        sda_m = 1'b1; waitq(Q);
        scl_i = 1'b1; waitq(Q);
        sda_m = 1'b0; waitq(Q);
        scl_i = 1'b0; waitq(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; waitq(Q);
        scl_i = 1'b1; waitq(Q);
        sda_m = 1'b1; waitq(2 * Q);
    endtask

    task automatic send_bit(input bit b);
        sda_m = b;    waitq(Q);
        scl_i = 1'b1; waitq(2 * Q);
        scl_i = 1'b0; waitq(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output bit ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; waitq(Q);
        scl_i = 1'b1; waitq(Q);
        ack = (sda_i == 1'b0);
        waitq(Q);
        scl_i = 1'b0; waitq(Q);
    endtask

    // Reference model works per transfer: an address/write match gates ACKs, and a
    // one-byte buffer that only the consumer empties decides accept versus overrun.
    task automatic xfer(input logic [6:0] addr, input bit rw, input logic [7:0] data[$], input bit rdy);
        bit ack;
        bit addr_ok;
        bit acc;
        m_axis_tready = rdy;
        oe_seen = 1'b0;
        addr_ok = (addr == own_addr) && !rw;
        i2c_start();
        write_byte({addr, rw}, ack);
        check("addr_ack", 32'(ack), 32'(addr_ok));
        check("busy_after_addr", 32'(busy), 32'(addr_ok));
        foreach (data[i]) begin
            acc = 1'b0;
            if (addr_ok) begin
                acc = !mdl_full || rdy;
                if (acc) begin
                    exp_q.push_back(data[i]);
                    if (!rdy) mdl_full = 1'b1;
                end else begin
                    mdl_ovr++;
                end
            end
            write_byte(data[i], ack);
            check("data_ack", 32'(ack), 32'(acc));
        end
        i2c_stop();
        check("busy_after_stop", 32'(busy), 32'd0);
        if (!addr_ok) check("oe_never", 32'(oe_seen), 32'd0);
    endtask

    task automatic drain();
        m_axis_tready = 1'b1;
        waitq(4);
        mdl_full = 1'b0;
        check("overrun_count", 32'(ovr_seen), 32'(mdl_ovr));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d[$];
        bit         ack;
        bit         got;
        logic [6:0] a;
        bit         rw;
        int         n;

        waitq(3);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        arst = 1'b0;
        waitq(4);

        d = {8'hA5};
        xfer(7'h50, 1'b0, d, 1'b1); drain();
        d = {8'h3C};
        xfer(7'h51, 1'b0, d, 1'b1); drain();
        d = {8'h99};
        xfer(7'h50, 1'b1, d, 1'b1); drain();

        d = {8'h11, 8'h22, 8'h33};
        xfer(7'h50, 1'b0, d, 1'b0);
        check("held_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("held_tdata", 32'(m_axis_tdata), 32'h11);
        drain();

        // Repeated START in the middle of a data byte.
        m_axis_tready = 1'b1;
        i2c_start();
        write_byte(8'hA0, ack);
        check("rs_addr_ack1", 32'(ack), 32'd1);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        i2c_start();
        check("rs_busy_kept", 32'(busy), 32'd1);
        write_byte(8'hA0, ack);
        check("rs_addr_ack2", 32'(ack), 32'd1);
        exp_q.push_back(8'h7E);
        write_byte(8'h7E, ack);
        check("rs_data_ack", 32'(ack), 32'd1);
        i2c_stop();
        drain();

        // Reset while the address ACK is being driven.
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(1'(8'hA0 >> i));
        sda_m = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (sda_oe) got = 1'b1;
        end
        check("oe_before_reset", 32'(got), 32'd1);
        arst = 1'b1;
        #1;
        check("arst_sda_oe", 32'(sda_oe), 32'd0);
        check("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("arst_tdata", 32'(m_axis_tdata), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        waitq(2);
        arst = 1'b0;
        sda_m = 1'b0; waitq(Q);
        scl_i = 1'b1; waitq(Q);
        sda_m = 1'b1; waitq(2 * Q);
        d = {8'h01};
        xfer(7'h50, 1'b0, d, 1'b1); drain();

        for (int t = 0; t < 8; t++) begin
            a  = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : 7'h50;
            rw = ($urandom_range(0, 4) == 0);
            n  = $urandom_range(1, 3);
            d  = {};
            for (int k = 0; k < n; k++) d.push_back(8'($urandom_range(0, 255)));
            xfer(a, rw, d, 1'($urandom_range(0, 1)));
            drain();
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
- I2C target (responder) for write transfers; the receive-side counterpart of our I2C master write FSM.
- Oversamples SCL/SDA on the system clock, detects START/STOP and matches the 7-bit address.
- ACKs address and data bytes by pulling SDA low, then presents each received byte on an AXI-Stream master port.
- Sits at the chip boundary behind an open-drain pad: SDA is driven low via sda_oe, released otherwise.

Parameters:
DATA_WIDTH, 8, bits per data byte; only 8 is supported on the bus.
ADDR_WIDTH, 7, target address width.

Ports:
clk  input  1  system clock; frequency must be at least 8x the SCL rate.
arst  input  1  asynchronous reset, active-high.
own_addr  input  ADDR_WIDTH  address this target responds to; sampled when the address byte completes.
scl_i  input  1  SCL pad input.
sda_i  input  1  SDA pad input.
sda_oe  output  1  1 = pull SDA low; 0 = release.
m_axis_tdata  output  DATA_WIDTH  received byte.
m_axis_tvalid  output  1  byte available.
m_axis_tready  input  1  downstream accepts.
busy  output  1  high from an addressed START until STOP.
overrun  output  1  one-cycle pulse when a byte is dropped.

Behaviour:
- Reset (async, arst=1): sda_oe=0, m_axis_tvalid=0, m_axis_tdata=0, busy=0, overrun=0, state=IDLE, synchronizers=1.
- Input conditioning:
  - scl_i and sda_i each pass through a 2-FF synchronizer, then one delay register (s_*, p_*).
  - scl_rise = s_scl & ~p_scl; scl_fall = ~s_scl & p_scl.
  - START = s_scl & p_scl & p_sda & ~s_sda; STOP = s_scl & p_scl & ~p_sda & s_sda.
  - Event latency from pad: 3 clk.
- Bit timing:
  - SDA is sampled on scl_rise, MSB first.
  - sda_oe changes only on scl_fall or on START/STOP/reset.
- States:
  - IDLE: sda_oe=0; START -> ADDR, bit counter = 7.
  - ADDR: shift 8 bits (7 address + R/W). On the 8th scl_rise:
    - address == own_addr and R/W=0 -> ACK_ADDR.
    - otherwise -> IGNORE (no ACK; reads are not supported).
  - ACK_ADDR: next scl_fall sets sda_oe=1 and busy=1. The following scl_fall clears sda_oe -> DATA, counter = 7.
  - DATA: shift 8 bits. On the 8th scl_rise the byte is complete:
    - if !m_axis_tvalid, or (m_axis_tvalid & m_axis_tready) in that same cycle: load m_axis_tdata, set tvalid=1 next cycle, ack_pending=1.
    - otherwise: drop the byte, pulse overrun, ack_pending=0.
    - -> ACK_DATA.
  - ACK_DATA: next scl_fall sets sda_oe=ack_pending. The following scl_fall clears sda_oe -> DATA. Multi-byte transfers are unbounded.
  - IGNORE: sda_oe=0; wait for START/STOP.
- AXIS handshake: tvalid held until tvalid & tready; tdata stable while tvalid=1.
- Output buffering: single-entry buffer only, no FIFO.
- Global events, in any state, taking priority over bit events in the same cycle:
  - STOP: -> IDLE, sda_oe=0, busy=0.
  - START (repeated): -> ADDR, counter = 7, sda_oe=0; busy stays until the address result.
- Simultaneous SCL and SDA change within one sample: no START/STOP is recognised; treated as a data-bit edge.
- A pending tvalid byte survives STOP, START and IGNORE; only arst clears it.
- arst mid-byte: immediate release of SDA, partial byte discarded; the target resumes at the next START.

Test Plan:
- own_addr=0x50; master writes addr 0x50 W, data 0xA5, STOP; tready=1 -> sda_oe high during both 9th clocks; one tvalid beat with tdata=0xA5; busy falls at STOP.
- Master writes addr 0x51 (own 0x50) with data 0x3C -> sda_oe never asserted; tvalid stays 0; state returns IDLE after STOP.
- Address 0x50 with R/W=1 -> no ACK, no tvalid, busy stays 0.
- Three bytes 0x11, 0x22, 0x33 with tready=0 -> 0x11 held and ACKed; 0x22 and 0x33 NACKed, overrun pulses twice; tdata stays 0x11 until tready=1.
- Repeated START after 4 data bits, then addr 0x50 W, data 0x7E -> partial byte discarded; tvalid with 0x7E only.
- arst asserted while sda_oe=1 during the address ACK -> sda_oe=0 in the same cycle and all outputs at reset values; a following transfer of 0x50 W/0x01 is received normally.
